// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parametrised UART receiver.
//   rx_state_e : receive FSM state encoding
//   PAR_EVEN / PAR_ODD : values of PAR_TYP
//   MIN_PRESC  : smallest oversampling ratio; lower Prescale values are clamped up
//   maj3       : 2-of-3 majority vote used by the bit sampler
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned MIN_PRESC = 4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Bit timing for the UART receiver.
// Ports:
//   clk, rst_n : oversampling clock, asynchronous active-low reset
//   start      : start edge seen this cycle; that cycle is count 0 of the start bit
//   active     : FSM is inside a frame (START/DATA/PARITY/STOP)
//   rx         : synchronised serial line
//   presc      : latched, already-clamped CLK cycles per bit
//   bit_tick   : majority decision available (count P/2+1)
//   bit_val    : 2-of-3 majority of the samples at P/2-1, P/2, P/2+1
//   bit_end    : last cycle of the bit (count P-1)
module uart_rx_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               active,
    input  logic               rx,
    input  logic [PRESC_W-1:0] presc,
    output logic               bit_tick,
    output logic               bit_val,
    output logic               bit_end
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic [PRESC_W-1:0] half;
    logic               s0_q, s0_d;
    logic               s1_q, s1_d;

    assign half = presc >> 1;

    always_comb begin
        cnt_d    = '0;
        s0_d     = s0_q;
        s1_d     = s1_q;
        bit_tick = 1'b0;
        bit_end  = 1'b0;
        // third sample is taken live from rx in the decision cycle
        bit_val  = maj3(s0_q, s1_q, rx);
        if (start) begin
            cnt_d = ONE;
        end else if (active) begin
            if (cnt_q == half - ONE) begin
                s0_d = rx;
            end
            if (cnt_q == half) begin
                s1_d = rx;
            end
            if (cnt_q == half + ONE) begin
                bit_tick = 1'b1;
            end
            if (cnt_q == presc - ONE) begin
                bit_end = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            s0_q  <= 1'b1;
            s1_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            s0_q  <= s0_d;
            s1_q  <= s1_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, frame FSM, shift register and checkers.
// Ports:
//   CLK, RST      : oversampling clock, asynchronous active-low reset
//   RX_IN         : serial line, idle high, asynchronous to CLK
//   PAR_EN/PAR_TYP: parity present / odd parity; latched at start edge
//   STOP2         : two stop bits; latched at start edge
//   Prescale      : CLK cycles per bit, clamped to >= 4; latched at start edge
//   P_DATA        : last error-free word
//   data_valid    : 1-cycle pulse, P_DATA updated
//   Parity_Error  : 1-cycle pulse, parity mismatch
//   Stop_Error    : 1-cycle pulse, a stop bit sampled 0
//   Break_Detect  : level, line held low for a whole frame; clears on RX_IN=1
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PRESC_W  = 6,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               STOP2,
    input  logic [PRESC_W-1:0] Prescale,
    output logic [DATA_W-1:0]  P_DATA,
    output logic               data_valid,
    output logic               Parity_Error,
    output logic               Stop_Error,
    output logic               Break_Detect
);

    localparam int unsigned BCNT_W = $clog2(DATA_W + 1);
    localparam logic [PRESC_W-1:0] PRESC_MIN = PRESC_W'(MIN_PRESC);

    rx_state_e state_q, state_d;

    logic [SYNC_STG-1:0] sync_q, sync_d;
    logic                rx_s;
    logic                rx_prev_q, rx_prev_d;

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                par_en_q, par_en_d;
    logic                par_typ_q, par_typ_d;
    logic                stop2_q, stop2_d;

    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic                par_err_q, par_err_d;
    logic                stop_err_q, stop_err_d;
    logic                all_zero_q, all_zero_d;

    logic [DATA_W-1:0]   pdata_q, pdata_d;
    logic                dv_q, dv_d;
    logic                perr_q, perr_d;
    logic                serr_q, serr_d;

    logic                start_det;
    logic                active;
    logic                bit_tick, bit_val, bit_end;
    logic [PRESC_W-1:0]  presc_clamped;
    logic                par_exp;

    assign sync_d    = {sync_q[SYNC_STG-2:0], RX_IN};
    assign rx_s      = sync_q[SYNC_STG-1];
    assign rx_prev_d = rx_s;

    // a 1->0 edge is required, so a line still low after BREAK cannot start a frame
    assign start_det = (state_q == ST_IDLE) && rx_prev_q && !rx_s;
    assign active    = (state_q == ST_START) || (state_q == ST_DATA) ||
                       (state_q == ST_PARITY) || (state_q == ST_STOP);

    assign presc_clamped = (Prescale < PRESC_MIN) ? PRESC_MIN : Prescale;
    assign par_exp       = (^sh_q) ^ (par_typ_q == PAR_ODD);

    uart_rx_bit_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk      (CLK),
        .rst_n    (RST),
        .start    (start_det),
        .active   (active),
        .rx       (rx_s),
        .presc    (presc_q),
        .bit_tick (bit_tick),
        .bit_val  (bit_val),
        .bit_end  (bit_end)
    );

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop2_d    = stop2_q;
        sh_d       = sh_q;
        bcnt_d     = bcnt_q;
        stop_cnt_d = stop_cnt_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        all_zero_d = all_zero_q;
        pdata_d    = pdata_q;
        dv_d       = 1'b0;
        perr_d     = 1'b0;
        serr_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_det) begin
                    presc_d    = presc_clamped;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    stop2_d    = STOP2;
                    sh_d       = '0;
                    bcnt_d     = '0;
                    stop_cnt_d = 1'b0;
                    par_err_d  = 1'b0;
                    stop_err_d = 1'b0;
                    all_zero_d = 1'b1;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                if (bit_tick && bit_val) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (bit_tick) begin
                    sh_d   = {bit_val, sh_q[DATA_W-1:1]};
                    bcnt_d = bcnt_q + BCNT_W'(1);
                    if (bit_val) begin
                        all_zero_d = 1'b0;
                    end
                end
                // bcnt_d, not bcnt_q: at Prescale 4 tick and bit end share a cycle
                if (bit_end && (bcnt_d == BCNT_W'(DATA_W))) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end

            ST_PARITY: begin
                if (bit_tick) begin
                    par_err_d = (bit_val != par_exp);
                    if (bit_val) begin
                        all_zero_d = 1'b0;
                    end
                end
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                if (bit_tick) begin
                    if (!bit_val) begin
                        stop_err_d = 1'b1;
                    end else begin
                        all_zero_d = 1'b0;
                    end
                end
                // leave at the mid-bit decision of the last stop bit so a
                // following start bit with no idle gap is not missed
                if (bit_tick && (stop_cnt_q == stop2_q)) begin
                    if (par_err_d || stop_err_d) begin
                        perr_d = par_err_d;
                        serr_d = stop_err_d;
                    end else begin
                        dv_d    = 1'b1;
                        pdata_d = sh_q;
                    end
                    state_d = all_zero_d ? ST_BREAK : ST_IDLE;
                end else if (bit_end) begin
                    stop_cnt_d = 1'b1;
                end
            end

            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            sync_q     <= '1;
            rx_prev_q  <= 1'b1;
            presc_q    <= PRESC_MIN;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            sh_q       <= '0;
            bcnt_q     <= '0;
            stop_cnt_q <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            all_zero_q <= 1'b0;
            pdata_q    <= '0;
            dv_q       <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            rx_prev_q  <= rx_prev_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            sh_q       <= sh_d;
            bcnt_q     <= bcnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            all_zero_q <= all_zero_d;
            pdata_q    <= pdata_d;
            dv_q       <= dv_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
        end
    end

    assign P_DATA       = pdata_q;
    assign data_valid   = dv_q;
    assign Parity_Error = perr_q;
    assign Stop_Error   = serr_q;
    assign Break_Detect = (state_q == ST_BREAK);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: frames are driven bit by bit, outputs are
// watched on the falling clock edge, expectations are hand-computed constants.
module tb_uart_rx_param;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned PRESC_W  = 6;
    localparam int unsigned SYNC_STG = 2;

    logic               CLK = 1'b0;
    logic               RST = 1'b0;
    logic               RX_IN = 1'b1;
    logic               PAR_EN = 1'b0;
    logic               PAR_TYP = 1'b0;
    logic               STOP2 = 1'b0;
    logic [PRESC_W-1:0] Prescale = 6'd16;
    logic [DATA_W-1:0]  P_DATA;
    logic               data_valid;
    logic               Parity_Error;
    logic               Stop_Error;
    logic               Break_Detect;

    int unsigned total = 0;
    int unsigned bad   = 0;

    int unsigned cyc = 0;
    int unsigned dv_n = 0, pe_n = 0, se_n = 0, wide_n = 0;
    int unsigned dv_cyc = 0, stop_cyc = 0;
    logic [DATA_W-1:0] dv_last = '0, dv_prev = '0;
    logic dv_d1 = 1'b0, pe_d1 = 1'b0, se_d1 = 1'b0;

    int unsigned bitp = 16;
    int unsigned b_dv, b_pe, b_se;

    uart_rx_param #(
        .DATA_W   (DATA_W),
        .PRESC_W  (PRESC_W),
        .SYNC_STG (SYNC_STG)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .STOP2        (STOP2),
        .Prescale     (Prescale),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .Parity_Error (Parity_Error),
        .Stop_Error   (Stop_Error),
        .Break_Detect (Break_Detect)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (data_valid) begin
            dv_n    = dv_n + 1;
            dv_prev = dv_last;
            dv_last = P_DATA;
            dv_cyc  = cyc;
        end
        if (Parity_Error) pe_n = pe_n + 1;
        if (Stop_Error)   se_n = se_n + 1;
        if ((data_valid && dv_d1) || (Parity_Error && pe_d1) || (Stop_Error && se_d1))
            wide_n = wide_n + 1;
        dv_d1 = data_valid;
        pe_d1 = Parity_Error;
        se_d1 = Stop_Error;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic hold(input logic b, input int unsigned n);
        RX_IN = b;
        repeat (n) tick();
    endtask

    task automatic base();
        b_dv = dv_n;
        b_pe = pe_n;
        b_se = se_n;
    endtask

    // chg: alter the config pins right after the start bit, restored afterwards
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic use_par,
                              input logic pbit, input logic two, input logic s1,
                              input logic s2, input logic chg);
        logic [PRESC_W-1:0] sv_p;
        logic sv_pe, sv_s2;
        sv_p  = Prescale;
        sv_pe = PAR_EN;
        sv_s2 = STOP2;
        hold(1'b0, bitp);
        if (chg) begin
            Prescale = 6'd8;
            PAR_EN   = ~PAR_EN;
            STOP2    = ~STOP2;
        end
        for (int i = 0; i < DATA_W; i++) hold(d[i], bitp);
        if (use_par) hold(pbit, bitp);
        stop_cyc = cyc;
        hold(s1, bitp);
        if (two) hold(s2, bitp);
        RX_IN = 1'b1;
        if (chg) begin
            Prescale = sv_p;
            PAR_EN   = sv_pe;
            STOP2    = sv_s2;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_pdata", 32'(P_DATA), 32'h0);
        chk("rst_dv", 32'(data_valid), 32'h0);
        chk("rst_pe", 32'(Parity_Error), 32'h0);
        chk("rst_se", 32'(Stop_Error), 32'h0);
        chk("rst_bd", 32'(Break_Detect), 32'h0);
        RST = 1'b1;
        hold(1'b1, 20);

        // 1: P=16, 8N1, 0xA5
        bitp = 16; Prescale = 6'd16;
        base();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 2 * bitp);
        chk("t1_dv", dv_n - b_dv, 1);
        chk("t1_data", 32'(P_DATA), 32'hA5);
        chk("t1_pe", pe_n - b_pe, 0);
        chk("t1_se", se_n - b_se, 0);
        chk("t1_latency", dv_cyc - stop_cyc, 16 / 2 + 1 + SYNC_STG + 1);

        // 2: parity
        bitp = 8; Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        base();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 2 * bitp);
        chk("t2_pe", pe_n - b_pe, 1);
        chk("t2_dv", dv_n - b_dv, 0);
        chk("t2_se", se_n - b_se, 0);
        chk("t2_hold", 32'(P_DATA), 32'hA5);
        base();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 2 * bitp);
        chk("t2_even_ok", dv_n - b_dv, 1);
        chk("t2_even_data", 32'(P_DATA), 32'h07);
        PAR_TYP = 1'b1;
        base();
        send_frame(8'h0E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 2 * bitp);
        chk("t2_odd_ok", dv_n - b_dv, 1);
        chk("t2_odd_data", 32'(P_DATA), 32'h0E);
        chk("t2_odd_pe", pe_n - b_pe, 0);
        PAR_EN = 1'b0; PAR_TYP = 1'b0;

        // 3: two stop bits
        STOP2 = 1'b1;
        base();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        hold(1'b1, 2 * bitp);
        chk("t3a_se", se_n - b_se, 1);
        chk("t3a_dv", dv_n - b_dv, 0);
        chk("t3a_pe", pe_n - b_pe, 0);
        base();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 2 * bitp);
        chk("t3b_se", se_n - b_se, 1);
        chk("t3b_dv", dv_n - b_dv, 0);
        chk("t3b_data", 32'(P_DATA), 32'h0E);
        base();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 2 * bitp);
        chk("t3c_dv", dv_n - b_dv, 1);
        chk("t3c_data", 32'(P_DATA), 32'h5A);
        STOP2 = 1'b0;

        // 4: start glitch
        bitp = 16; Prescale = 6'd16;
        base();
        hold(1'b0, 2);
        hold(1'b1, 3 * bitp);
        chk("t4_dv", dv_n - b_dv, 0);
        chk("t4_se", se_n - b_se, 0);
        chk("t4_pe", pe_n - b_pe, 0);
        chk("t4_data", 32'(P_DATA), 32'h5A);
        chk("t4_bd", 32'(Break_Detect), 32'h0);
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 2 * bitp);
        chk("t4_next", 32'(P_DATA), 32'h96);

        // mid-frame config change must not affect the frame in flight
        base();
        send_frame(8'h3A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        hold(1'b1, 2 * bitp);
        chk("cfg_dv", dv_n - b_dv, 1);
        chk("cfg_data", 32'(P_DATA), 32'h3A);
        chk("cfg_err", (pe_n - b_pe) + (se_n - b_se), 0);

        // Prescale below 4 behaves as 4
        Prescale = 6'd2; bitp = 4;
        base();
        send_frame(8'hC6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 4 * bitp);
        chk("clamp_dv", dv_n - b_dv, 1);
        chk("clamp_data", 32'(P_DATA), 32'hC6);

        // 5: back-to-back frames, zero gap
        bitp = 32; Prescale = 6'd32;
        base();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 2 * bitp);
        chk("t5_dv", dv_n - b_dv, 2);
        chk("t5_first", 32'(dv_prev), 32'h3C);
        chk("t5_second", 32'(dv_last), 32'hC3);

        // 6: line break
        bitp = 16; Prescale = 6'd16;
        base();
        hold(1'b0, 3 * 10 * bitp);
        chk("t6_se", se_n - b_se, 1);
        chk("t6_bd", 32'(Break_Detect), 32'h1);
        chk("t6_dv", dv_n - b_dv, 0);
        chk("t6_pe", pe_n - b_pe, 0);
        hold(1'b1, 2 * bitp);
        chk("t6_bd_clr", 32'(Break_Detect), 32'h0);
        base();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 2 * bitp);
        chk("t6_next_dv", dv_n - b_dv, 1);
        chk("t6_next_data", 32'(P_DATA), 32'h55);

        // 7: reset in the middle of the data bits
        hold(1'b0, bitp);
        hold(1'b1, bitp);
        hold(1'b0, bitp / 2);
        RST = 1'b0;
        #2;
        chk("t7_pdata", 32'(P_DATA), 32'h0);
        chk("t7_dv", 32'(data_valid), 32'h0);
        chk("t7_bd", 32'(Break_Detect), 32'h0);
        RX_IN = 1'b1;
        repeat (3) tick();
        RST = 1'b1;
        base();
        hold(1'b1, 3 * bitp);
        chk("t7_quiet", (dv_n - b_dv) + (pe_n - b_pe) + (se_n - b_se), 0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 2 * bitp);
        chk("t7_dv", dv_n - b_dv, 1);
        chk("t7_data", 32'(P_DATA), 32'h81);

        chk("pulse_width", wide_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
